// File: rtl/loop_nest_scheduler_if.sv
// Start/stall handshake and iteration-issue bus between kernel control and the loop nest scheduler.
interface loop_nest_scheduler_if #(
  parameter int IDX_W = 16
);
  logic             start;
  logic             stall;
  logic             busy;
  logic             issue;
  logic [IDX_W-1:0] inner_idx;
  logic [IDX_W-1:0] outer_idx;
  logic             last;
  logic             done;

  modport master (
    output start, stall,
    input  busy, issue, inner_idx, outer_idx, last, done
  );

  modport slave (
    input  start, stall,
    output busy, issue, inner_idx, outer_idx, last, done
  );
endinterface

// File: rtl/loop_nest_scheduler.sv
// Two-level pipelined loop nest sequencer: one iteration issue every II unstalled clocks.
// Define LOOP_SCHED_DRAIN_EN to hold done off until the datapath (LATENCY clocks deep) has drained.
module loop_nest_scheduler #(
  parameter int N_INNER = 4,
  parameter int N_OUTER = 2,
  parameter int II      = 1,
  parameter int LATENCY = 3,
  parameter int IDX_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  loop_nest_scheduler_if.slave bus
);

`ifdef LOOP_SCHED_DRAIN_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // A one-deep datapath is already drained on the cycle after the last issue.
  localparam state_t AFTER_LAST = (LATENCY == 1) ? DONE : DRAIN;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam state_t AFTER_LAST = DONE;
`endif

  localparam logic [IDX_W-1:0] INNER_MAX = IDX_W'(N_INNER - 1);
  localparam logic [IDX_W-1:0] OUTER_MAX = IDX_W'(N_OUTER - 1);
  localparam logic [31:0]      II_MAX    = 32'(II - 1);

  if (N_INNER < 1 || N_OUTER < 1 || II < 1 || LATENCY < 1 ||
      longint'(N_INNER) > (longint'(1) << IDX_W) ||
      longint'(N_OUTER) > (longint'(1) << IDX_W)) begin : g_bad_params
    $error("loop_nest_scheduler: illegal parameter combination");
  end

  state_t           state;
  state_t           state_next;
  logic [31:0]      ii_cnt;
  logic [31:0]      ii_wrap;
  logic [IDX_W-1:0] inner_q;
  logic [IDX_W-1:0] outer_q;
  logic             final_iter;

  assign final_iter = (inner_q == INNER_MAX) && (outer_q == OUTER_MAX);
  assign ii_wrap    = (ii_cnt == II_MAX) ? 32'd0 : ii_cnt + 32'd1;

`ifdef LOOP_SCHED_DRAIN_EN
  logic [31:0] drain_cnt;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch on any path).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.issue && bus.last) ? AFTER_LAST : RUN;
      RUN:     if (bus.issue && bus.last) state_next = AFTER_LAST;
`ifdef LOOP_SCHED_DRAIN_EN
      // drain_cnt reaches LATENCY on the same edge that enters DONE.
      DRAIN:   if (!bus.stall && drain_cnt == 32'(LATENCY - 1)) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE) || bus.start;
    bus.issue = 1'b0;
    case (state)
      IDLE:    bus.issue = bus.start && !bus.stall;
      RUN:     bus.issue = (ii_cnt == 32'd0) && !bus.stall;
      default: bus.issue = 1'b0;
    endcase
    bus.last      = bus.issue && final_iter;
    bus.done      = (state == DONE);
    bus.inner_idx = inner_q;
    bus.outer_idx = outer_q;
  end

  // Index/interval bookkeeping; IDLE keeps ii_cnt at 0 so a stalled start issues on its first free cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ii_cnt  <= '0;
      inner_q <= '0;
      outer_q <= '0;
    end else if (bus.issue) begin
      if (final_iter) begin
        ii_cnt  <= '0;
        inner_q <= '0;
        outer_q <= '0;
      end else begin
        ii_cnt <= ii_wrap;
        if (inner_q == INNER_MAX) begin
          inner_q <= '0;
          outer_q <= outer_q + IDX_W'(1);
        end else begin
          inner_q <= inner_q + IDX_W'(1);
        end
      end
    end else if (state == RUN && !bus.stall) begin
      ii_cnt <= ii_wrap;
    end
  end

`ifdef LOOP_SCHED_DRAIN_EN
  always_ff @(posedge clk) begin
    if (rst)                               drain_cnt <= '0;
    else if (bus.last)                     drain_cnt <= 32'd1;
    else if (state == DRAIN && !bus.stall) drain_cnt <= drain_cnt + 32'd1;
    else if (state == DONE)                drain_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Directed bench for loop_nest_scheduler: three instances (3x2 II=2, 4x1 II=1, 1x1) with hand-derived traces.
module tb_loop_nest_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef LOOP_SCHED_DRAIN_EN
  localparam int DRAIN_LAT = 3;
`else
  localparam int DRAIN_LAT = 1;
`endif
  localparam int DONE_A = 10 + DRAIN_LAT;  // 3x2, II=2: last issue at cycle 10
  localparam int DONE_B = 5 + DRAIN_LAT;   // 4x1, II=1, stalled 2 cycles: last issue at 5
  localparam int DONE_C = DRAIN_LAT;       // 1x1: last issue at 0

  always #5 clk = ~clk;

  loop_nest_scheduler_if #(.IDX_W(16)) bus_a ();
  loop_nest_scheduler_if #(.IDX_W(16)) bus_b ();
  loop_nest_scheduler_if #(.IDX_W(16)) bus_c ();

  loop_nest_scheduler #(.N_INNER(3), .N_OUTER(2), .II(2), .LATENCY(3), .IDX_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  loop_nest_scheduler #(.N_INNER(4), .N_OUTER(1), .II(1), .LATENCY(3), .IDX_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  loop_nest_scheduler #(.N_INNER(1), .N_OUTER(1), .II(1), .LATENCY(3), .IDX_W(16)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  // Expected {busy, issue, last, done} for dut_a, k cycles after an unstalled start.
  function automatic logic [3:0] exp_a_flags(int k);
    return {(k >= 0) && (k <= DONE_A), (k >= 0) && (k <= 10) && (k % 2 == 0),
            k == 10, k == DONE_A};
  endfunction

  // Expected {outer_idx, inner_idx} for dut_a at issue cycle k.
  function automatic logic [31:0] exp_a_idx(int k);
    case (k)
      0:       return {16'd0, 16'd0};
      2:       return {16'd0, 16'd1};
      4:       return {16'd0, 16'd2};
      6:       return {16'd1, 16'd0};
      8:       return {16'd1, 16'd1};
      10:      return {16'd1, 16'd2};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp += 6;
    if ({bus_a.busy, bus_a.issue, bus_a.last, bus_a.done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags_a: got %b want 0000", {bus_a.busy, bus_a.issue, bus_a.last, bus_a.done});
    end
    if ({bus_b.busy, bus_b.issue, bus_b.last, bus_b.done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags_b: got %b want 0000", {bus_b.busy, bus_b.issue, bus_b.last, bus_b.done});
    end
    if ({bus_c.busy, bus_c.issue, bus_c.last, bus_c.done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags_c: got %b want 0000", {bus_c.busy, bus_c.issue, bus_c.last, bus_c.done});
    end
    if ({bus_a.outer_idx, bus_a.inner_idx} !== 32'd0) begin
      n_bad++; $display("FAIL reset_idx_a: got %h want 0", {bus_a.outer_idx, bus_a.inner_idx});
    end
    if ({bus_b.outer_idx, bus_b.inner_idx} !== 32'd0) begin
      n_bad++; $display("FAIL reset_idx_b: got %h want 0", {bus_b.outer_idx, bus_b.inner_idx});
    end
    if ({bus_c.outer_idx, bus_c.inner_idx} !== 32'd0) begin
      n_bad++; $display("FAIL reset_idx_c: got %h want 0", {bus_c.outer_idx, bus_c.inner_idx});
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_nest_ii2();
    logic [3:0] exp;
    for (int c = 0; c <= DONE_A + 1; c++) begin
      bus_a.start = (c == 0);
      @(negedge clk);
      exp = exp_a_flags(c);
      n_cmp++;
      if ({bus_a.busy, bus_a.issue, bus_a.last, bus_a.done} !== exp) begin
        n_bad++;
        $display("FAIL nest_ii2_flags cyc %0d: got %b want %b", c, {bus_a.busy, bus_a.issue, bus_a.last, bus_a.done}, exp);
      end
      if (exp[2]) begin
        n_cmp++;
        if ({bus_a.outer_idx, bus_a.inner_idx} !== exp_a_idx(c)) begin
          n_bad++;
          $display("FAIL nest_ii2_idx cyc %0d: got %h want %h", c, {bus_a.outer_idx, bus_a.inner_idx}, exp_a_idx(c));
        end
      end
      next_cycle();
    end
    bus_a.start = 1'b0;
  endtask

  task automatic test_stall_ii1();
    logic [3:0]  exp;
    logic [15:0] exp_inner;
    for (int c = 0; c <= DONE_B + 1; c++) begin
      bus_b.start = (c == 0);
      bus_b.stall = (c == 2) || (c == 3);
      @(negedge clk);
      exp = {c <= DONE_B, c inside {0, 1, 4, 5}, c == 5, c == DONE_B};
      n_cmp++;
      if ({bus_b.busy, bus_b.issue, bus_b.last, bus_b.done} !== exp) begin
        n_bad++;
        $display("FAIL stall_ii1_flags cyc %0d: got %b want %b", c, {bus_b.busy, bus_b.issue, bus_b.last, bus_b.done}, exp);
      end
      if (exp[2]) begin
        exp_inner = (c < 2) ? 16'(c) : 16'(c - 2);
        n_cmp++;
        if ({bus_b.outer_idx, bus_b.inner_idx} !== {16'd0, exp_inner}) begin
          n_bad++;
          $display("FAIL stall_ii1_idx cyc %0d: got %h want %h", c, {bus_b.outer_idx, bus_b.inner_idx}, {16'd0, exp_inner});
        end
      end
      next_cycle();
    end
    bus_b.start = 1'b0;
    bus_b.stall = 1'b0;
  endtask

  task automatic test_single_iter();
    logic [3:0] exp;
    for (int c = 0; c <= DONE_C + 1; c++) begin
      bus_c.start = (c == 0);
      @(negedge clk);
      exp = {c <= DONE_C, c == 0, c == 0, c == DONE_C};
      n_cmp++;
      if ({bus_c.busy, bus_c.issue, bus_c.last, bus_c.done} !== exp) begin
        n_bad++;
        $display("FAIL single_flags cyc %0d: got %b want %b", c, {bus_c.busy, bus_c.issue, bus_c.last, bus_c.done}, exp);
      end
      if (c == 0) begin
        n_cmp++;
        if ({bus_c.outer_idx, bus_c.inner_idx} !== 32'd0) begin
          n_bad++;
          $display("FAIL single_idx: got %h want 0", {bus_c.outer_idx, bus_c.inner_idx});
        end
      end
      next_cycle();
    end
    bus_c.start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp;
    int         k;
    for (int c = 0; c <= 6 + DONE_A + 1; c++) begin
      bus_a.start = (c == 0) || (c == 6);
      rst         = (c == 3);
      @(negedge clk);
      k   = (c <= 3) ? c : c - 6;
      exp = (c == 4 || c == 5) ? 4'b0000 : exp_a_flags(k);
      n_cmp++;
      if ({bus_a.busy, bus_a.issue, bus_a.last, bus_a.done} !== exp) begin
        n_bad++;
        $display("FAIL rst_mid_flags cyc %0d: got %b want %b", c, {bus_a.busy, bus_a.issue, bus_a.last, bus_a.done}, exp);
      end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if ({bus_a.outer_idx, bus_a.inner_idx} !== 32'd0) begin
          n_bad++;
          $display("FAIL rst_mid_idx cyc %0d: got %h want 0", c, {bus_a.outer_idx, bus_a.inner_idx});
        end
      end else if (exp[2]) begin
        n_cmp++;
        if ({bus_a.outer_idx, bus_a.inner_idx} !== exp_a_idx(k)) begin
          n_bad++;
          $display("FAIL rst_mid_idx cyc %0d: got %h want %h", c, {bus_a.outer_idx, bus_a.inner_idx}, exp_a_idx(k));
        end
      end
      next_cycle();
    end
    bus_a.start = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int         issues;
    int         k;
    // Run 1: start re-pulsed mid-run and in the DONE cycle must be ignored.
    issues = 0;
    for (int c = 0; c <= DONE_A + 1; c++) begin
      bus_a.start = (c == 0) || (c == 2) || (c == DONE_A);
      @(negedge clk);
      exp = exp_a_flags(c);
      if (bus_a.issue === 1'b1) issues++;
      n_cmp++;
      if ({bus_a.busy, bus_a.issue, bus_a.last, bus_a.done} !== exp) begin
        n_bad++;
        $display("FAIL b2b_flags cyc %0d: got %b want %b", c, {bus_a.busy, bus_a.issue, bus_a.last, bus_a.done}, exp);
      end
      next_cycle();
    end
    n_cmp++;
    if (issues !== 6) begin
      n_bad++; $display("FAIL b2b_issue_count: got %0d want 6", issues);
    end
    // Run 2: start arrives while stalled; first issue lands on the first free cycle (2).
    issues = 0;
    for (int c = 0; c <= DONE_A + 3; c++) begin
      bus_a.start = (c == 0);
      bus_a.stall = (c <= 1);
      @(negedge clk);
      k   = c - 2;
      exp = (c <= 1) ? 4'b1000 : exp_a_flags(k);
      if (bus_a.issue === 1'b1) issues++;
      n_cmp++;
      if ({bus_a.busy, bus_a.issue, bus_a.last, bus_a.done} !== exp) begin
        n_bad++;
        $display("FAIL stalled_start_flags cyc %0d: got %b want %b", c, {bus_a.busy, bus_a.issue, bus_a.last, bus_a.done}, exp);
      end
      if (exp[2]) begin
        n_cmp++;
        if ({bus_a.outer_idx, bus_a.inner_idx} !== exp_a_idx(k)) begin
          n_bad++;
          $display("FAIL stalled_start_idx cyc %0d: got %h want %h", c, {bus_a.outer_idx, bus_a.inner_idx}, exp_a_idx(k));
        end
      end
      next_cycle();
    end
    bus_a.start = 1'b0;
    bus_a.stall = 1'b0;
    n_cmp++;
    if (issues !== 6) begin
      n_bad++; $display("FAIL stalled_start_issue_count: got %0d want 6", issues);
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.stall = 1'b0;
    bus_b.start = 1'b0; bus_b.stall = 1'b0;
    bus_c.start = 1'b0; bus_c.stall = 1'b0;
    test_reset();
    next_cycle();
    test_nest_ii2();
    next_cycle();
    test_stall_ii1();
    next_cycle();
    test_single_iter();
    next_cycle();
    test_reset_mid_run();
    next_cycle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
